// File: rtl/word_decode_fifo.sv
// word_decode_fifo
// Small show-ahead FIFO that buffers 16-bit instruction words from the
// time-multiplexed processor stage. It splits the head word into
// opcode/rd/rs/imm fields for the execute stage. Words with opcode 0 can be
// discarded at the input and counted. Words that arrive while the FIFO is
// full are dropped and flagged with a sticky error bit.
module word_decode_fifo #(
  parameter int DEPTH    = 4,
  parameter int DROP_NOP = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_opcode,
  output logic [3:0]               out_rd,
  output logic [3:0]               out_rs,
  output logic [3:0]               out_imm,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow_err,
  output logic [7:0]               nop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  // Storage has no reset: its contents only matter behind a valid level.
  logic [15:0]      mem_reg [DEPTH];
  logic [DEPTH-1:0] wr_en;

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0] level_reg, level_next;
  logic          overflow_err_reg, overflow_err_next;
  logic [7:0]    nop_count_reg, nop_count_next;

  logic        is_nop;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [15:0] head_word;

  // Input classification and handshake qualification.
  always_comb begin
    full   = (level_reg == FULL_LEVEL);
    empty  = (level_reg == '0);
    is_nop = in_valid && (DROP_NOP != 0) && (in_data[15:12] == 4'h0);
    // Space is judged on the current level only, so a same-cycle pop
    // does not let a word into a full FIFO.
    push   = in_valid && !is_nop && !full;
    pop    = !empty && out_ready;
  end

  // One write enable per entry, selected by the write pointer.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  // Store an accepted word into the entry selected by the write pointer.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        mem_reg[i] <= in_data;
      end
    end
  end

  // Next-state for the pointers, the occupancy and the status counters.
  always_comb begin
    wr_ptr_next       = wr_ptr_reg;
    rd_ptr_next       = rd_ptr_reg;
    level_next        = level_reg;
    overflow_err_next = overflow_err_reg;
    nop_count_next    = nop_count_reg;

    // Pointers are AW bits wide and DEPTH is a power of two,
    // so they wrap on their own.
    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end

    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase

    if (in_valid && !is_nop && full) begin
      overflow_err_next = 1'b1;
    end

    if (is_nop && (nop_count_reg != 8'hFF)) begin
      nop_count_next = nop_count_reg + 8'd1;
    end
  end

  // Control state registers with an asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      level_reg        <= '0;
      overflow_err_reg <= 1'b0;
      nop_count_reg    <= 8'h00;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      level_reg        <= level_next;
      overflow_err_reg <= overflow_err_next;
      nop_count_reg    <= nop_count_next;
    end
  end

  // Show-ahead head decode; the fields read as zero while nothing is queued.
  always_comb begin
    head_word    = mem_reg[rd_ptr_reg];
    out_valid    = !empty;
    in_ready     = !full;
    out_opcode   = out_valid ? head_word[15:12] : 4'h0;
    out_rd       = out_valid ? head_word[11:8]  : 4'h0;
    out_rs       = out_valid ? head_word[7:4]   : 4'h0;
    out_imm      = out_valid ? head_word[3:0]   : 4'h0;
    level        = level_reg;
    overflow_err = overflow_err_reg;
    nop_count    = nop_count_reg;
  end

endmodule

// File: tb/tb_word_decode_fifo.sv
// tb_word_decode_fifo
// Randomized and directed stimulus for word_decode_fifo. The bench keeps a
// queue-based reference model of the FIFO contents, the sticky overflow flag
// and the NOP counter, and compares every DUT output against it each cycle.
module tb_word_decode_fifo;

  localparam int DEPTH    = 4;
  localparam int DROP_NOP = 1;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   in_data = 16'h0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_opcode;
  logic [3:0]    out_rd;
  logic [3:0]    out_rs;
  logic [3:0]    out_imm;
  logic [LW-1:0] level;
  logic          overflow_err;
  logic [7:0]    nop_count;

  int cmp_count = 0;
  int err_count = 0;

  // Reference model state
  logic [15:0] model_q[$];
  bit          model_ovf = 1'b0;
  int          model_nop = 0;

  word_decode_fifo #(.DEPTH(DEPTH), .DROP_NOP(DROP_NOP)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_rd       (out_rd),
    .out_rs       (out_rs),
    .out_imm      (out_imm),
    .level        (level),
    .overflow_err (overflow_err),
    .nop_count    (nop_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dut_head();
    return {out_opcode, out_rd, out_rs, out_imm};
  endfunction

  // Compare every output against the model's current state.
  task automatic check_outputs(input string tag);
    logic [15:0] head;
    bit          has;
    has  = (model_q.size() != 0);
    head = has ? model_q[0] : 16'h0000;
    check_val({tag, "/out_valid"}, out_valid, has);
    check_val({tag, "/in_ready"}, in_ready, model_q.size() != DEPTH);
    check_val({tag, "/level"}, level, model_q.size());
    check_val({tag, "/head"}, dut_head(), head);
    check_val({tag, "/overflow"}, overflow_err, model_ovf);
    check_val({tag, "/nop_count"}, nop_count, model_nop);
  endtask

  function automatic void model_clear();
    model_q.delete();
    model_ovf = 1'b0;
    model_nop = 0;
  endfunction

  // One clock: drive inputs, check at the falling edge, advance the model,
  // then return 1 time unit after the rising edge.
  task automatic do_cycle(input logic vin, input logic [15:0] d, input logic ordy, input string tag);
    bit          nop;
    bit          was_full;
    bit          do_pop;
    logic [15:0] w;
    in_valid  = vin;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    check_outputs(tag);
    nop      = vin && (DROP_NOP != 0) && (d[15:12] == 4'h0);
    was_full = (model_q.size() == DEPTH);
    do_pop   = (model_q.size() != 0) && ordy;
    if (do_pop) begin
      w = model_q.pop_front();
      $display("%s: pop %04h", tag, w);
    end
    if (nop) begin
      if (model_nop < 255) model_nop++;
    end else if (vin) begin
      if (was_full) model_ovf = 1'b1;
      else model_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 16'h0;
    #1;
    model_clear();
    check_outputs(tag);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_heads [4];
    logic [15:0] d;

    // Reset and single push
    apply_reset("reset0");
    do_cycle(1'b1, 16'h2933, 1'b0, "t1_push");
    check_val("t1_opcode", out_opcode, 4'h2);
    check_val("t1_rd", out_rd, 4'h9);
    check_val("t1_rs", out_rs, 4'h3);
    check_val("t1_imm", out_imm, 4'h3);
    check_val("t1_level", level, 1);
    check_val("t1_in_ready", in_ready, 1'b1);
    check_val("t1_out_valid", out_valid, 1'b1);

    // Fill, overflow, drain in order
    do_cycle(1'b1, 16'h293F, 1'b0, "t2_push");
    do_cycle(1'b1, 16'h2803, 1'b0, "t2_push");
    do_cycle(1'b1, 16'h88F3, 1'b0, "t2_push");
    check_val("t2_level_full", level, 4);
    check_val("t2_in_ready_full", in_ready, 1'b0);
    do_cycle(1'b1, 16'h5133, 1'b0, "t2_over");
    check_val("t2_overflow", overflow_err, 1'b1);
    check_val("t2_level_after_over", level, 4);
    exp_heads[0] = 16'h2933; exp_heads[1] = 16'h293F;
    exp_heads[2] = 16'h2803; exp_heads[3] = 16'h88F3;
    for (int i = 0; i < 4; i++) begin
      check_val("t2_head_order", dut_head(), exp_heads[i]);
      do_cycle(1'b0, 16'h0000, 1'b1, "t2_pop");
    end
    check_val("t2_drained", out_valid, 1'b0);

    // NOP dropping, including while full
    apply_reset("reset_t3");
    do_cycle(1'b1, 16'h0133, 1'b0, "t3_nop");
    do_cycle(1'b1, 16'h1133, 1'b0, "t3_push");
    check_val("t3_nop_count", nop_count, 1);
    check_val("t3_level", level, 1);
    check_val("t3_head", dut_head(), 16'h1133);
    do_cycle(1'b1, 16'h1234, 1'b0, "t3_push");
    do_cycle(1'b1, 16'h2345, 1'b0, "t3_push");
    do_cycle(1'b1, 16'h3456, 1'b0, "t3_push");
    do_cycle(1'b1, 16'h0FFF, 1'b0, "t3_nop_full");
    check_val("t3_nop_count_full", nop_count, 2);
    check_val("t3_no_overflow", overflow_err, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 16'h0000, 1'b1, "t3_pop");

    // Steady stream at level 2 across pointer wraps
    apply_reset("reset_t4");
    do_cycle(1'b1, 16'h7D30, 1'b0, "t4_fill");
    do_cycle(1'b1, 16'h7D31, 1'b0, "t4_fill");
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b1, 16'h7D30 + 16'(i + 2), 1'b1, "t4_stream");
      check_val("t4_level_steady", level, 2);
    end
    do_cycle(1'b0, 16'h0000, 1'b1, "t4_drain");
    do_cycle(1'b0, 16'h0000, 1'b1, "t4_drain");

    // Asynchronous reset mid-stream
    apply_reset("reset_t5");
    do_cycle(1'b1, 16'h0001, 1'b0, "t5_nop");
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 16'h4100 + 16'(i), 1'b0, "t5_fill");
    do_cycle(1'b0, 16'h0000, 1'b1, "t5_pop");
    check_val("t5_level3", level, 3);
    check_val("t5_ovf_before", overflow_err, 1'b1);
    in_valid  = 1'b1;
    in_data   = 16'h4444;
    out_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check_val("t5_async_out_valid", out_valid, 1'b0);
    check_val("t5_async_level", level, 0);
    check_val("t5_async_overflow", overflow_err, 1'b0);
    check_val("t5_async_nop", nop_count, 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_cycle(1'b1, 16'hABCD, 1'b0, "t5_fresh");
    check_val("t5_fresh_level", level, 1);
    check_val("t5_fresh_head", dut_head(), 16'hABCD);

    // NOP counter saturation
    apply_reset("reset_t6");
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'b1;
      in_data   = {4'h0, 12'($urandom)};
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
    end
    check_val("t6_nop_sat", nop_count, 8'hFF);
    check_val("t6_level", level, 0);
    check_val("t6_no_overflow", overflow_err, 1'b0);

    // Randomized traffic against the model
    apply_reset("reset_rand");
    for (int i = 0; i < 400; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d[15:12] = 4'h0;
      do_cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0), "rand");
    end
    for (int i = 0; i < DEPTH + 1; i++) do_cycle(1'b0, 16'h0000, 1'b1, "rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule

// File: doc/word_decode_fifo.md
Name: word_decode_fifo

Overview:
Downstream consumer of the two-source time-multiplexed processor stage. It accepts the 16-bit words that stage emits, qualified by its read strobe, and buffers them in a small FIFO. It splits each word into opcode/rd/rs/imm fields and presents them to the execute stage over a valid/ready handshake. It absorbs bursts from the 4-cycle upstream schedule and reports drops.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
DROP_NOP, 1, when 1, words with opcode 4'h0 are discarded at input and never stored

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_data  input  16  word from upstream stage
in_valid  input  1  upstream strobe (driven from upstream reg_read); word offered this cycle
in_ready  output  1  1 when FIFO not full
out_valid  output  1  head entry available
out_ready  input  1  execute stage accepts head this cycle
out_opcode  output  4  head[15:12]
out_rd  output  4  head[11:8]
out_rs  output  4  head[7:4]
out_imm  output  4  head[3:0]
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow_err  output  1  sticky: a valid non-dropped word arrived while full
nop_count  output  8  number of words discarded as NOP; saturates at 8'hFF

Behaviour:
- Reset: asserted whenever reset=0, asynchronously. Clears wr_ptr, rd_ptr, level, overflow_err and nop_count to 0. Storage contents are don't-care. Outputs after reset: in_ready=1, out_valid=0, out_* fields = 0.
- Output fields are forced to 0 whenever out_valid=0.
- in_ready = (level != DEPTH). Combinational from level only; a pop in the same cycle does not free space.
- Classification: an offered word is a NOP when in_valid=1, DROP_NOP=1 and in_data[15:12]=0.
- NOP handling: a NOP is never stored and does not change level. It increments nop_count (saturating), regardless of full state.
- Push: in_valid=1, word not NOP and in_ready=1. Writes mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Overflow: in_valid=1, word not NOP and level=DEPTH. The word is dropped and overflow_err is set to 1. overflow_err stays 1 until reset.
- out_valid = (level != 0). Head is show-ahead: fields are decoded combinationally from mem[rd_ptr].
- Latency: a word pushed at edge N is visible on out_* with out_valid=1 immediately after edge N if the FIFO was empty.
- Pop: out_valid=1 and out_ready=1. rd_ptr increments modulo DEPTH at the edge.
- out_ready with out_valid=0 is ignored.
- Level update per edge: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Simultaneous push and pop is legal whenever 0 < level < DEPTH.
- When empty, only a push can occur; the same word cannot be pushed and popped in the same cycle.
- Pointers wrap from DEPTH-1 to 0 with no bubble. Ordering is strict FIFO.
- Holding: while out_valid=1 and out_ready=0, all out_* stay stable.
- Reset mid-operation: all queued words are discarded and the handshake is abandoned. The first word after reset release is treated as a fresh push.
- A level-held upstream strobe is pushed once per cycle it is high; de-duplication is upstream's responsibility.

Test Plan:
- Reset, then release; in_valid=1, in_data=16'h2933 for 1 cycle, out_ready=0 -> after the edge: out_valid=1, opcode=2, rd=9, rs=3, imm=3, level=1, in_ready=1.
- Push 16'h2933, 16'h293F, 16'h2803, 16'h88F3 on consecutive cycles, out_ready=0 -> level=4, in_ready=0. A 5th push of 16'h5133 sets overflow_err=1 with level still 4. Then out_ready=1 for 4 cycles -> heads 2933, 293F, 2803, 88F3 in order, then out_valid=0.
- DROP_NOP=1: push 16'h0133 then 16'h1133 -> nop_count=1, level=1, head opcode=1, rd=1, rs=3, imm=3. Offer a NOP while full -> nop_count increments and overflow_err stays 0.
- Steady stream: level=2, in_valid=1 and out_ready=1 for 10 cycles with 16'h7D33 and incrementing imm -> level stays 2. Output order matches input order across at least two pointer wraps.
- Reset asserted (reset=0) mid-stream with level=3, out_valid=1 -> out_valid=0, level=0, overflow_err=0, nop_count=0 immediately, without waiting for a clock edge.
- nop_count saturation: offer 300 NOP words -> nop_count=8'hFF and level=0.
